trig_capture_mc: RTL

Multi-channel, single-clock trigger/capture engine, the parametrised successor of the scope sampling block. Decimates incoming ADC samples and records NCH channels into a circular buffer with programmable pre-trigger depth. Triggers on a selectable channel with edge polarity and hysteresis, and supports normal, single, auto and free-run modes. Streams the captured record out in chronological order over a valid/ready port to the readout/UART path.

---
 rtl/trig_capture_mc.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/trig_capture_mc.sv
// Multi-channel trigger/capture engine. Decimated samples from NCH channels are written into
// a circular buffer. A selectable edge (with hysteresis) or a forced/auto trigger ends the wait.
// The record is then streamed out in chronological order over a valid/ready port.
module trig_capture_mc #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DW    = 12,
  parameter int unsigned ASIZE = 9,
  parameter int unsigned DEC_W = 16,
  parameter int unsigned TO_W  = 24,
  localparam int unsigned TSW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                CLK100MHz,
  input  logic                rst,
  input  logic [NCH*DW-1:0]   din,
  input  logic                din_valid,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [TSW-1:0]      trig_src,
  input  logic                trig_edge,
  input  logic [DW-1:0]       trig_level,
  input  logic [DW-1:0]       trig_hyst,
  input  logic [ASIZE-1:0]    pretrig,
  input  logic [DEC_W-1:0]    decim,
  input  logic [TO_W-1:0]     auto_timeout,
  input  logic                force_trig,
  output logic [NCH*DW-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic [2:0]          state,
  output logic [ASIZE-1:0]    trig_index,
  output logic                auto_fired
);

  localparam int unsigned D = 1 << ASIZE;
  localparam logic [ASIZE:0] NBEATS = {1'b1, {ASIZE{1'b0}}};

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StRead = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DEC_W-1:0]        decim_cnt_q, decim_cnt_d;
  logic [ASIZE-1:0]        cnt_q, cnt_d;
  logic [ASIZE-1:0]        wr_addr_q, wr_addr_d;
  logic [ASIZE-1:0]        rd_addr_q, rd_addr_d;
  logic [ASIZE-1:0]        trig_index_q, trig_index_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    hflag_q, hflag_d;
  logic                    force_lat_q, force_lat_d;
  logic                    auto_fired_q, auto_fired_d;
  logic [ASIZE:0]          iss_cnt_q, iss_cnt_d;
  logic                    s1_v_q, s1_v_d;
  logic                    s1_last_q, s1_last_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [NCH*DW-1:0]       rd_data_q, rd_data_d;
  logic [NCH*DW-1:0]       mem_rd_q;
  // Record buffer; contents are deliberately not reset.
  logic [NCH*DW-1:0]       buf_mem [D];

  logic                    acc, wr_en, rd_en, s1_adv, out_ready, hs;
  logic [ASIZE-1:0]        pretrig_eff, post_len;
  logic [DW-1:0]           tsamp, thr_lo, thr_hi;
  logic [DW:0]             hi_sum;
  logic                    edge_hit, arm_cond, timeout_hit, auto_force, force_any;

  // pretrig is ASIZE bits wide, so it can never exceed D-1 and needs no clamp.
  assign pretrig_eff = pretrig;
  assign post_len    = {ASIZE{1'b1}} - pretrig_eff;
  assign acc         = din_valid && (decim_cnt_q == decim);
  assign out_ready   = !rd_valid_q || rd_ready;
  assign hs          = rd_valid_q && rd_ready;

  // Pick the trigger channel and derive saturated hysteresis thresholds.
  always_comb begin
    tsamp = din[DW-1:0];
    for (int i = 0; i < NCH; i++) begin
      if (int'(trig_src) == i) tsamp = din[i*DW +: DW];
    end
    thr_lo = (trig_level >= trig_hyst) ? trig_level - trig_hyst : '0;
    hi_sum = {1'b0, trig_level} + {1'b0, trig_hyst};
    thr_hi = hi_sum[DW] ? {DW{1'b1}} : hi_sum[DW-1:0];
    arm_cond    = trig_edge ? (tsamp > thr_hi) : (tsamp < thr_lo);
    edge_hit    = hflag_q && (trig_edge ? (tsamp <= trig_level) : (tsamp >= trig_level));
    timeout_hit = (to_cnt_q == auto_timeout);
    auto_force  = (mode == 2'b10) && timeout_hit;
    force_any   = force_lat_q || force_trig || auto_force || (mode == 2'b11);
  end

  // Next-state logic: acquisition FSM, buffer pointers and the two-stage read pipeline.
  always_comb begin
    state_d      = state_q;
    decim_cnt_d  = decim_cnt_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    trig_index_d = trig_index_q;
    to_cnt_d     = to_cnt_q;
    hflag_d      = hflag_q;
    force_lat_d  = force_lat_q;
    auto_fired_d = auto_fired_q;
    iss_cnt_d    = iss_cnt_q;
    s1_v_d       = s1_v_q;
    s1_last_d    = s1_last_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data_d    = rd_data_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    s1_adv       = 1'b0;

    if (din_valid) decim_cnt_d = acc ? '0 : decim_cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (arm) state_d = StPre;
      end
      StPre: begin
        if (acc) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if ((pretrig_eff == '0) || (acc && (cnt_q == pretrig_eff - 1'b1))) state_d = StWait;
      end
      StWait: begin
        if (!timeout_hit) to_cnt_d = to_cnt_q + 1'b1;
        if (force_trig) force_lat_d = 1'b1;
        if (acc) begin
          wr_en = 1'b1;
          if (arm_cond) hflag_d = 1'b1;
          if (edge_hit || force_any) begin
            trig_index_d = wr_addr_q;
            force_lat_d  = 1'b0;
            cnt_d        = '0;
            // A real edge wins over a coincident force.
            if (edge_hit) begin
              hflag_d      = 1'b0;
              auto_fired_d = 1'b0;
            end else if (auto_force) begin
              auto_fired_d = 1'b1;
            end
            state_d = (post_len == '0) ? StRead : StPost;
          end
        end
      end
      StPost: begin
        if (acc) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == post_len - 1'b1) state_d = StRead;
        end
      end
      StRead: begin
        s1_adv = s1_v_q && out_ready;
        if (out_ready) begin
          rd_valid_d = s1_v_q;
          rd_last_d  = s1_v_q && s1_last_q;
        end
        if (s1_adv) rd_data_d = mem_rd_q;
        // Issue a read whenever stage 1 is empty or draining this cycle.
        if ((iss_cnt_q != NBEATS) && (!s1_v_q || s1_adv)) begin
          rd_en     = 1'b1;
          s1_v_d    = 1'b1;
          s1_last_d = (iss_cnt_q == NBEATS - 1'b1);
          iss_cnt_d = iss_cnt_q + 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end else if (s1_adv) begin
          s1_v_d = 1'b0;
        end
        if (hs && rd_last_q) state_d = (mode == 2'b01) ? StIdle : StPre;
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) wr_addr_d = wr_addr_q + 1'b1;

    if (state_d != state_q) begin
      if (state_d == StPre) begin
        decim_cnt_d = '0;
        cnt_d       = '0;
        hflag_d     = 1'b0;
        force_lat_d = 1'b0;
      end
      if (state_d == StWait) to_cnt_d = '0;
      if (state_d == StRead) begin
        iss_cnt_d  = '0;
        rd_addr_d  = trig_index_d - pretrig_eff;
        s1_v_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
      end
    end

    if (abort) begin
      state_d     = StIdle;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      s1_v_d      = 1'b0;
      s1_last_d   = 1'b0;
      decim_cnt_d = '0;
      cnt_d       = '0;
      to_cnt_d    = '0;
      iss_cnt_d   = '0;
      wr_addr_d   = '0;
      rd_addr_d   = '0;
      hflag_d     = 1'b0;
      force_lat_d = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
    end
  end

  // Control and pipeline registers with synchronous reset.
  always_ff @(posedge CLK100MHz) begin
    if (rst) begin
      state_q      <= StIdle;
      decim_cnt_q  <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      trig_index_q <= '0;
      to_cnt_q     <= '0;
      hflag_q      <= 1'b0;
      force_lat_q  <= 1'b0;
      auto_fired_q <= 1'b0;
      iss_cnt_q    <= '0;
      s1_v_q       <= 1'b0;
      s1_last_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      decim_cnt_q  <= decim_cnt_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      trig_index_q <= trig_index_d;
      to_cnt_q     <= to_cnt_d;
      hflag_q      <= hflag_d;
      force_lat_q  <= force_lat_d;
      auto_fired_q <= auto_fired_d;
      iss_cnt_q    <= iss_cnt_d;
      s1_v_q       <= s1_v_d;
      s1_last_q    <= s1_last_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Buffer write port and registered (enable-held) read port.
  always_ff @(posedge CLK100MHz) begin
    if (wr_en && !rst) buf_mem[wr_addr_q] <= din;
    if (rd_en) mem_rd_q <= buf_mem[rd_addr_q];
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign state      = state_q;
  assign trig_index = trig_index_q;
  assign auto_fired = auto_fired_q;

endmodule
